// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer port bundle: display read path, host write path and the RAM port.
// The arbiter takes the slave view; the surrounding logic or a bench takes the master view.
interface fb_port_arbiter_if #(
   parameter int ADDR_W      = 17,
   parameter int DATA_W      = 12,
   parameter int WFIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(WFIFO_DEPTH + 1);

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_hold;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [LVL_W-1:0]  wfifo_level;

   modport slave (
      input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, wr_hold, mem_rdata,
      output rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata, wfifo_level
   );

   modport master (
      output rd_req, rd_addr, wr_valid, wr_addr, wr_data, wr_hold, mem_rdata,
      input  rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata, wfifo_level
   );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win with a fixed 2-clock latency,
// host writes queue in a small FIFO and drain into otherwise idle memory cycles.
module fb_port_arbiter #(
   parameter int ADDR_W      = 17,
   parameter int DATA_W      = 12,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   fb_port_arbiter_if.slave    bus
);
   localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
   localparam int LVL_W = $clog2(WFIFO_DEPTH + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

   wr_entry_t        fifo_mem [WFIFO_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [LVL_W-1:0] level;
   logic             push;
   logic             pop;
   logic             issued;
   logic             returning;

   // Ready comes from the registered level only, so a full FIFO refuses a push even
   // in the cycle it pops; it also reads low for as long as reset is held.
   assign bus.wr_ready    = reset && (level < LVL_W'(WFIFO_DEPTH));
   assign bus.wfifo_level = level;

   assign push = bus.wr_valid && bus.wr_ready;
   assign pop  = !bus.rd_req && !bus.wr_hold && (level != '0);

   // NOTE: storage arrays carry no reset; only the pointers and level define what is valid,
   // which keeps the array a plain RAM/register file without a reset tree.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[tail] <= '{addr: bus.wr_addr, data: bus.wr_data};
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head          <= '0;
         tail          <= '0;
         level         <= '0;
         issued        <= 1'b0;
         returning     <= 1'b0;
         bus.rd_valid  <= 1'b0;
         bus.rd_data   <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);

         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase

         // Read tag pipeline never stalls; rd_data keeps its last value between pulses.
         issued       <= bus.rd_req;
         returning    <= issued;
         bus.rd_valid <= returning;
         if (returning) bus.rd_data <= bus.mem_rdata;

         if (bus.rd_req) begin
            bus.mem_en   <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.rd_addr;
         end else if (pop) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= fifo_mem[head].addr;
            bus.mem_wdata <= fifo_mem[head].data;
         end else begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: reset, streaming reads, FIFO fill/drain,
// read priority, full boundary and reset during an in-flight read.
module tb_fb_port_arbiter;
   localparam int ADDR_W = 17;
   localparam int DATA_W = 12;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(DEPTH)) bus ();

   fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // RAM model: synchronous read returning the low 12 address bits one clock later.
   always @(posedge clk or negedge reset) begin
      if (!reset)                         bus.mem_rdata <= '0;
      else if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= bus.mem_addr[11:0];
   end

   task automatic check(input string tag, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int pulses;
      int exp_lvl [5];

      reset        = 1'b0;
      bus.rd_req   = 1'b0;
      bus.rd_addr  = '0;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 17'h0055;
      bus.wr_data  = 12'h055;
      bus.wr_hold  = 1'b0;

      // Reset held for 3 clocks with a write offered.
      repeat (3) tick();
      check("rst_level",    int'(bus.wfifo_level), 0);
      check("rst_mem_en",   int'(bus.mem_en), 0);
      check("rst_mem_we",   int'(bus.mem_we), 0);
      check("rst_mem_addr", int'(bus.mem_addr), 0);
      check("rst_mem_wd",   int'(bus.mem_wdata), 0);
      check("rst_rd_valid", int'(bus.rd_valid), 0);
      check("rst_rd_data",  int'(bus.rd_data), 0);
      check("rst_wr_ready", int'(bus.wr_ready), 0);
      bus.wr_valid = 1'b0;
      reset        = 1'b1;
      #1;
      check("rel_wr_ready", int'(bus.wr_ready), 1);
      tick();
      check("rel_level", int'(bus.wfifo_level), 0);

      // Streaming reads 0x100..0x107.
      pulses = 0;
      for (int t = 0; t < 12; t++) begin
         bus.rd_req  = (t < 8);
         bus.rd_addr = ADDR_W'(32'h100 + t);
         tick();
         if (t < 8) begin
            check("rd_mem_en",   int'(bus.mem_en), 1);
            check("rd_mem_we",   int'(bus.mem_we), 0);
            check("rd_mem_addr", int'(bus.mem_addr), 32'h100 + t);
         end else begin
            check("rd_idle", int'(bus.mem_en), 0);
         end
         check("rd_valid", int'(bus.rd_valid), (t >= 2 && t < 10) ? 1 : 0);
         if (t >= 2) check("rd_data", int'(bus.rd_data), (t < 10) ? 32'h100 + t - 2 : 32'h107);
         if (bus.rd_valid) pulses++;
      end
      check("rd_pulses", pulses, 8);

      // Fill with hold: five offers, four accepted.
      bus.wr_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = ADDR_W'(32'h200 + i);
         bus.wr_data  = DATA_W'(32'hA00 + i);
         #1;
         check("fill_ready", int'(bus.wr_ready), (i < 4) ? 1 : 0);
         tick();
         check("fill_level", int'(bus.wfifo_level), (i < 4) ? i + 1 : 4);
         check("fill_no_mem", int'(bus.mem_en), 0);
      end
      check("full_ready", int'(bus.wr_ready), 0);

      // Release hold with the 5th write still offered: rejected on the pop edge,
      // accepted on the next one, then five writes drain back to back in order.
      bus.wr_hold = 1'b0;
      exp_lvl = '{3, 3, 2, 1, 0};
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 1) bus.wr_valid = 1'b0;
         check("drain_en",    int'(bus.mem_en), 1);
         check("drain_we",    int'(bus.mem_we), 1);
         check("drain_addr",  int'(bus.mem_addr), 32'h200 + i);
         check("drain_wdata", int'(bus.mem_wdata), 32'hA00 + i);
         check("drain_level", int'(bus.wfifo_level), exp_lvl[i]);
         if (i == 0) check("drain_ready", int'(bus.wr_ready), 1);
      end
      tick();
      check("drain_idle", int'(bus.mem_en), 0);

      // Read priority over two queued writes.
      bus.wr_hold = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = ADDR_W'(32'h300 + i);
         bus.wr_data  = DATA_W'(32'hB00 + i);
         tick();
      end
      bus.wr_valid = 1'b0;
      bus.wr_hold  = 1'b0;
      check("pri_level0", int'(bus.wfifo_level), 2);
      for (int u = 0; u < 7; u++) begin
         bus.rd_req  = (u < 3);
         bus.rd_addr = ADDR_W'(32'h110 + u);
         tick();
         if (u < 3) begin
            check("pri_rd_we",   int'(bus.mem_we), 0);
            check("pri_rd_addr", int'(bus.mem_addr), 32'h110 + u);
            check("pri_level",   int'(bus.wfifo_level), 2);
         end else if (u < 5) begin
            check("pri_wr_we",   int'(bus.mem_we), 1);
            check("pri_wr_addr", int'(bus.mem_addr), 32'h300 + u - 3);
            check("pri_wr_data", int'(bus.mem_wdata), 32'hB00 + u - 3);
         end else begin
            check("pri_idle", int'(bus.mem_en), 0);
         end
         check("pri_rd_valid", int'(bus.rd_valid), (u >= 2 && u < 5) ? 1 : 0);
         if (u >= 2 && u < 5) check("pri_rd_data", int'(bus.rd_data), 32'h110 + u - 2);
      end

      // Reset one clock after a read request, with a write still queued.
      bus.wr_hold  = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 17'h0400;
      bus.wr_data  = 12'hC00;
      tick();
      bus.wr_valid = 1'b0;
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 17'h0120;
      tick();
      bus.rd_req = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      check("mid_rst_level", int'(bus.wfifo_level), 0);
      check("mid_rst_en",    int'(bus.mem_en), 0);
      check("mid_rst_valid", int'(bus.rd_valid), 0);
      @(posedge clk);
      #1;
      reset       = 1'b1;
      bus.wr_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_valid", int'(bus.rd_valid), 0);
         check("post_rst_en",    int'(bus.mem_en), 0);
         check("post_rst_level", int'(bus.wfifo_level), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single-port frame-buffer RAM between the display read path (pixel fetch driven by the VGA core's read pointers) and a host write path (pixel loader). Display reads have absolute priority and a fixed, never-stalled latency; host writes are buffered in a small FIFO and drained into idle memory cycles. Sits in the 36 MHz pixel-clock domain between the pixel cache / VGA core and the RAM primitive.

## Interface

Parameters:
- `ADDR_W`, 17: frame-buffer address width.
- `DATA_W`, 12: pixel width (4:4:4 RGB).
- `WFIFO_DEPTH`, 4: write FIFO entries; power of two, 2 or greater.

Ports:
- `clk` in 1: pixel clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `rd_req` in 1: display read request, one per cycle, no handshake.
- `rd_addr` in ADDR_W: display read address.
- `rd_valid` out 1: `rd_data` valid this cycle.
- `rd_data` out DATA_W: read pixel.
- `wr_valid` in 1: host write offered.
- `wr_ready` out 1: FIFO can accept.
- `wr_addr` in ADDR_W, `wr_data` in DATA_W: host write payload.
- `wr_hold` in 1: when high, the FIFO is not drained (used for tear-free update).
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: RAM port, all registered.
- `mem_rdata` in DATA_W: RAM read data, valid the cycle after the access cycle.
- `wfifo_level` out clog2(WFIFO_DEPTH+1): current FIFO occupancy.

## Operation

- **Arbitration**, evaluated each edge from sampled inputs:
  - `rd_req`=1: issue a read. Always granted.
  - Otherwise, if FIFO is non-empty and `wr_hold`=0: pop the head and issue a write.
  - Otherwise: idle (`mem_en`=0, `mem_we`=0).
- **Read pipeline:** 2-stage tag shift register (`issued`, `returning`). It is independent of write traffic, so back-to-back reads stream at one pixel per clock.
- **Write FIFO:**
  - Circular buffer with wrapping head/tail pointers and a level register.
  - Push on `wr_valid && wr_ready`.
  - `wr_ready` = (`wfifo_level` < WFIFO_DEPTH), driven from the registered level.
- **Full:** `wr_ready`=0 even if a pop occurs in the same cycle; there is no pass-through.
- **Empty:** an entry pushed at edge k is first eligible for pop at edge k+1.
- **Push and pop in the same cycle:** level is unchanged and pointers both advance.
- **Pointer wrap:** modulo WFIFO_DEPTH.
- **Ordering:** writes reach memory in acceptance order. There is no read-after-write forwarding; a read of an address still in the FIFO returns old memory contents.
- **Starvation:** a continuous `rd_req` stream starves writes indefinitely. This is intended, because reads fall only in active video and blanking drains the FIFO.
- **Reset:** asynchronous assertion at any point:
  - FIFO is emptied and pointers are zeroed.
  - In-flight read tags are cleared, so a pending `rd_valid` is dropped.
  - All outputs go to their reset values.

## Timing

- **Reset values:**
  - `rd_valid`=0, `rd_data`=0.
  - `wr_ready`=1 once reset is released. It is 0 while reset is asserted.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `wfifo_level`=0.
- **Read request:** `rd_req`/`rd_addr` sampled at edge k. After edge k: `mem_en`=1, `mem_we`=0, `mem_addr`=`rd_addr`.
- **Read return:** `mem_rdata` is valid during cycle k+1 and is captured at edge k+2. `rd_valid`=1 and `rd_data` are valid during the cycle after edge k+2. Fixed latency is 2 clocks, with no exceptions.
- **Holding read data:** `rd_data` holds its last value while `rd_valid`=0.
- **Write pop:** popped at edge k. After edge k: `mem_en`=1, `mem_we`=1, with `mem_addr`/`mem_wdata` taken from the FIFO head.
- **Minimum write latency:** accept at edge k, then memory write issued after edge k+1, given an empty FIFO, `wr_hold`=0 and `rd_req`=0.
- **`wr_hold`:** sampled like `rd_req`; takes effect on the next edge.

## Test plan

- **Reset:** hold `reset`=0 for 3 clocks with `wr_valid`=1 → no push, `wfifo_level`=0, `mem_en`=0, all outputs at reset values.
- **Streaming reads:** `rd_req`=1 for 8 cycles, addresses 0x100..0x107, memory model returns addr[11:0] → `rd_valid` high for exactly 8 cycles starting 2 clocks after the first sampling edge, data 0x100..0x107 in order.
- **FIFO fill and drain:**
  - `wr_hold`=1, push 5 writes → first 4 accepted, `wr_ready`=0 and `wfifo_level`=4 after the 4th.
  - Release `wr_hold` → 4 memory writes on consecutive cycles in order.
  - Then `wr_ready` returns to 1 and the 5th write is accepted.
- **Read priority:** FIFO holds 2 writes, `rd_req` asserted for 3 cycles → 3 reads issued first with unchanged latency, then the 2 writes drain on the next 2 cycles.
- **Full boundary:** at level 4, assert `wr_valid` in the same cycle as a pop → the push is rejected, level goes 4→3, and the push is accepted on the next cycle.
- **Reset mid-read:** reset asserted 1 clock after `rd_req` → no `rd_valid` pulse after release, FIFO empty, `mem_en`=0.
